// File: rtl/acc_pkg.sv
// Shared types and op encodings for the round-robin accumulator arbiter.
package acc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    localparam logic OP_AND = 1'b0;
    localparam logic OP_XOR = 1'b1;

endpackage

// File: rtl/acc_unit.sv
// WIDTH-bit XOR/AND accumulator register; clr wins over an enabled update.
module acc_unit
    import acc_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             r,
    input  logic             clr,
    input  logic             en,
    input  logic             op,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = Q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = (op == OP_XOR) ? (Q ^ operand) : (Q & operand);
        end
    end

    always_ff @(posedge clk) begin
        if (r) begin
            Q <= '0;
        end else begin
            Q <= q_d;
        end
    end

endmodule

// File: rtl/acc_arbiter.sv
// Round-robin arbiter that serialises XOR/AND requests onto one shared accumulator.
module acc_arbiter
    import acc_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N_REQ = 4
) (
    input  logic                   clk,
    input  logic                   r,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       sel,
    input  logic [N_REQ*WIDTH-1:0] data,
    input  logic                   clr,
    output logic [N_REQ-1:0]       gnt,
    output logic                   busy,
    output logic [WIDTH-1:0]       Q,
    output logic [3:0]             L,
    output logic [7:0]             ops
);

    localparam int unsigned PTR_W = $clog2(N_REQ);

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   win_q, win_d;
    logic               op_q, op_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [7:0]         ops_q, ops_d;
    logic               exec_en;

    logic               arb_found;
    logic [PTR_W-1:0]   arb_win;
    logic               arb_op;
    logic [WIDTH-1:0]   arb_opnd;

    // Rotating priority: first pass covers ptr..N_REQ-1, second pass wraps to 0..ptr-1.
    always_comb begin
        arb_found = 1'b0;
        arb_win   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!arb_found && req[i] && (PTR_W'(i) >= ptr_q)) begin
                arb_found = 1'b1;
                arb_win   = PTR_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!arb_found && req[i]) begin
                arb_found = 1'b1;
                arb_win   = PTR_W'(i);
            end
        end
    end

    always_comb begin
        arb_op   = OP_AND;
        arb_opnd = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (PTR_W'(i) == arb_win) begin
                arb_op   = sel[i];
                arb_opnd = data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        ops_d   = ops_q;
        exec_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_found) begin
                    win_d   = arb_win;
                    op_d    = arb_op;
                    opnd_d  = arb_opnd;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                exec_en = 1'b1;
                // A colliding clr discards the op but it still counts as consumed.
                if (!clr) begin
                    ops_d = ops_q + 8'd1;
                end
                ptr_d   = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + PTR_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            op_q    <= OP_AND;
            opnd_q  <= '0;
            ops_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            ops_q   <= ops_d;
        end
    end

    acc_unit #(
        .WIDTH(WIDTH)
    ) u_acc_unit (
        .clk    (clk),
        .r      (r),
        .clr    (clr),
        .en     (exec_en),
        .op     (op_q),
        .operand(opnd_q),
        .Q      (Q)
    );

    // Reset landing on an EXEC cycle suppresses the acknowledge for the lost op.
    always_comb begin
        gnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            gnt[i] = (state_q == EXEC) && !r && (win_q == PTR_W'(i));
        end
    end

    assign busy = (state_q == EXEC);
    assign L    = Q[WIDTH-1 -: 4];
    assign ops  = ops_q;

    a_gnt_onehot: assert property (@(posedge clk) $onehot0(gnt));
    a_exec_single: assert property (@(posedge clk) disable iff (r)
        (state_q == EXEC) |=> (state_q == IDLE));

endmodule

// File: tb/tb_acc_arbiter.sv
// Scoreboard bench for acc_arbiter: a transaction model predicts winner, Q and ops per grant.
module tb_acc_arbiter;

    localparam int WIDTH = 8;
    localparam int N_REQ = 4;

    logic                   clk = 1'b0;
    logic                   r;
    logic [N_REQ-1:0]       req;
    logic [N_REQ-1:0]       sel;
    logic [N_REQ*WIDTH-1:0] data;
    logic                   clr;
    logic [N_REQ-1:0]       gnt;
    logic                   busy;
    logic [WIDTH-1:0]       Q;
    logic [3:0]             L;
    logic [7:0]             ops;

    always #5 clk = ~clk;

    acc_arbiter #(
        .WIDTH(WIDTH),
        .N_REQ(N_REQ)
    ) dut (
        .clk (clk),
        .r   (r),
        .req (req),
        .sel (sel),
        .data(data),
        .clr (clr),
        .gnt (gnt),
        .busy(busy),
        .Q   (Q),
        .L   (L),
        .ops (ops)
    );

    typedef struct {
        logic [3:0] g;
        logic [7:0] q;
        logic [7:0] n;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mq;
    logic [7:0] mops;
    int         mptr;
    int         checks   = 0;
    int         failures = 0;

    function automatic int pick(logic [3:0] rv);
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (mptr + k) % N_REQ;
            if (rv[idx]) return idx;
        end
        return 0;
    endfunction

    function automatic void push_op(int who, bit cleared);
        exp_t       e;
        logic [7:0] d;
        d = data[who*8 +: 8];
        if (cleared) begin
            mq = 8'h00;
        end else begin
            mq   = sel[who] ? (mq ^ d) : (mq & d);
            mops = mops + 8'd1;
        end
        mptr  = (who + 1) % N_REQ;
        e.g   = 4'b0000;
        e.g[who] = 1'b1;
        e.q   = mq;
        e.n   = mops;
        sb.push_back(e);
    endfunction

    function automatic void model_reset();
        mq   = 8'h00;
        mops = 8'h00;
        mptr = 0;
    endfunction

    task automatic wait_gnt(output logic [3:0] g, output bit to, output int n);
        to = 1'b1;
        g  = 4'b0000;
        n  = 0;
        while (n < 20 && to) begin
            @(negedge clk);
            n++;
            if (gnt !== 4'b0000) begin
                g  = gnt;
                to = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        r = 1'b1; clr = 1'b0; req = 4'hF; sel = 4'hF; data = 32'h0804_0201;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (gnt !== 4'b0000) begin
                failures++; $display("FAIL reset_gnt: got %b expected 0000", gnt);
            end
            checks++;
            if (busy !== 1'b0) begin
                failures++; $display("FAIL reset_busy: got %b expected 0", busy);
            end
        end
        checks++;
        if (Q !== 8'h00) begin failures++; $display("FAIL reset_q: got %h expected 00", Q); end
        checks++;
        if (ops !== 8'h00) begin failures++; $display("FAIL reset_ops: got %h expected 00", ops); end
        checks++;
        if (L !== 4'h0) begin failures++; $display("FAIL reset_l: got %h expected 0", L); end
        r = 1'b0; req = 4'b0000;
        model_reset();
    endtask

    task automatic test_single();
        exp_t e; logic [3:0] g; bit to; int n; logic [7:0] eq;
        @(negedge clk);
        sel[0] = 1'b1; data[7:0] = 8'hA5; req = 4'b0001;
        push_op(pick(req), 1'b0);
        wait_gnt(g, to, n);
        e = sb.pop_front();
        checks++;
        if (to || g !== e.g) begin
            failures++; $display("FAIL single_xor_gnt: got %b expected %b", g, e.g);
        end
        checks++;
        if (n !== 1) begin failures++; $display("FAIL single_latency: got %0d expected 1", n); end
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b expected 1", busy); end
        // Operands changed while in flight must not affect the result.
        data[7:0] = 8'h00; sel[0] = 1'b0; req = 4'b0000;
        @(negedge clk);
        eq = e.q;
        checks++;
        if (Q !== eq) begin failures++; $display("FAIL single_xor_q: got %h expected %h", Q, eq); end
        checks++;
        if (L !== eq[7:4]) begin failures++; $display("FAIL single_l: got %h expected %h", L, eq[7:4]); end
        checks++;
        if (ops !== e.n) begin failures++; $display("FAIL single_ops: got %h expected %h", ops, e.n); end

        sel[0] = 1'b0; data[7:0] = 8'h0F; req = 4'b0001;
        push_op(pick(req), 1'b0);
        wait_gnt(g, to, n);
        e = sb.pop_front();
        checks++;
        if (to || g !== e.g) begin
            failures++; $display("FAIL single_and_gnt: got %b expected %b", g, e.g);
        end
        req = 4'b0000;
        @(negedge clk);
        checks++;
        if (Q !== e.q) begin failures++; $display("FAIL single_and_q: got %h expected %h", Q, e.q); end
        checks++;
        if (ops !== e.n) begin failures++; $display("FAIL single_and_ops: got %h expected %h", ops, e.n); end
    endtask

    task automatic test_round_robin();
        exp_t e; logic [3:0] g; bit to; int n;
        logic [3:0] gl [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [7:0] ql [5] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h0E};
        @(negedge clk); r = 1'b1;
        @(negedge clk); r = 1'b0;
        sel = 4'hF; data = 32'h0804_0201; req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            e.g = gl[k]; e.q = ql[k]; e.n = 8'(k + 1);
            sb.push_back(e);
        end
        mq = 8'h0E; mops = 8'd5; mptr = 1;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(g, to, n);
            e = sb.pop_front();
            checks++;
            if (to || g !== e.g) begin
                failures++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, g, e.g);
            end
            checks++;
            if (n !== 1) begin failures++; $display("FAIL rr_spacing[%0d]: got %0d expected 1", k, n); end
            if (k == 4) req = 4'b0000;
            @(negedge clk);
            checks++;
            if (Q !== e.q || ops !== e.n) begin
                failures++;
                $display("FAIL rr_result[%0d]: got Q=%h ops=%h expected Q=%h ops=%h",
                         k, Q, ops, e.q, e.n);
            end
        end
    endtask

    task automatic test_pointer_skip();
        exp_t e; logic [3:0] g; bit to; int n;
        sel[1] = 1'b1; data[15:8] = 8'h02; req = 4'b0010;
        push_op(pick(req), 1'b0);
        wait_gnt(g, to, n);
        e = sb.pop_front();
        checks++;
        if (to || g !== e.g) begin failures++; $display("FAIL skip_setup_gnt: got %b expected %b", g, e.g); end
        req = 4'b0000;
        @(negedge clk);
        checks++;
        if (Q !== e.q) begin failures++; $display("FAIL skip_setup_q: got %h expected %h", Q, e.q); end

        sel[0] = 1'b1; data[7:0] = 8'h01; data[15:8] = 8'h02; req = 4'b0011;
        push_op(pick(4'b0011), 1'b0);
        push_op(pick(4'b0010), 1'b0);
        // Requester 3 posts only while EXEC runs and withdraws before IDLE.
        @(posedge clk); #1 req[3] = 1'b1;
        wait_gnt(g, to, n);
        e = sb.pop_front();
        checks++;
        if (to || g !== e.g) begin failures++; $display("FAIL skip_first_gnt: got %b expected %b", g, e.g); end
        req[3] = 1'b0; req[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (Q !== e.q || ops !== e.n) begin
            failures++; $display("FAIL skip_first_q: got Q=%h ops=%h expected Q=%h ops=%h", Q, ops, e.q, e.n);
        end
        wait_gnt(g, to, n);
        e = sb.pop_front();
        checks++;
        if (to || g !== e.g) begin failures++; $display("FAIL skip_second_gnt: got %b expected %b", g, e.g); end
        req = 4'b0000;
        @(negedge clk);
        checks++;
        if (Q !== e.q || ops !== e.n) begin
            failures++; $display("FAIL skip_second_q: got Q=%h ops=%h expected Q=%h ops=%h", Q, ops, e.q, e.n);
        end
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0000) begin failures++; $display("FAIL skip_no_stray: got %b expected 0000", gnt); end
    endtask

    task automatic test_clr();
        exp_t e; logic [3:0] g; bit to; int n;
        clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        mq = 8'h00;
        checks++;
        if (Q !== 8'h00 || ops !== mops || busy !== 1'b0) begin
            failures++; $display("FAIL clr_idle: got Q=%h ops=%h busy=%b expected Q=00 ops=%h busy=0",
                                 Q, ops, busy, mops);
        end
        sel[2] = 1'b1; data[23:16] = 8'h3C; req = 4'b0100;
        push_op(pick(req), 1'b0);
        wait_gnt(g, to, n);
        e = sb.pop_front();
        checks++;
        if (to || g !== e.g) begin failures++; $display("FAIL clr_setup_gnt: got %b expected %b", g, e.g); end
        req = 4'b0000;
        @(negedge clk);
        checks++;
        if (Q !== 8'h3C) begin failures++; $display("FAIL clr_setup_q: got %h expected 3c", Q); end

        sel[3] = 1'b1; data[31:24] = 8'hFF; req = 4'b1000;
        push_op(pick(req), 1'b1);
        @(posedge clk); #1 clr = 1'b1;
        wait_gnt(g, to, n);
        e = sb.pop_front();
        checks++;
        if (to || g !== e.g) begin failures++; $display("FAIL clr_exec_gnt: got %b expected %b", g, e.g); end
        req = 4'b0000;
        @(negedge clk); clr = 1'b0;
        checks++;
        if (Q !== e.q || ops !== e.n) begin
            failures++; $display("FAIL clr_exec_q: got Q=%h ops=%h expected Q=%h ops=%h", Q, ops, e.q, e.n);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e; logic [3:0] g; bit to; int n;
        sel[0] = 1'b1; sel[3] = 1'b1; data[7:0] = 8'h11; data[31:24] = 8'hFF; req = 4'b1001;
        push_op(pick(4'b1001), 1'b0);
        push_op(pick(4'b1000), 1'b0);
        for (int k = 0; k < 2; k++) begin
            wait_gnt(g, to, n);
            e = sb.pop_front();
            checks++;
            if (to || g !== e.g) begin failures++; $display("FAIL b2b_gnt[%0d]: got %b expected %b", k, g, e.g); end
            req = req & ~g;
            @(negedge clk);
            checks++;
            if (Q !== e.q || ops !== e.n) begin
                failures++;
                $display("FAIL b2b_q[%0d]: got Q=%h ops=%h expected Q=%h ops=%h", k, Q, ops, e.q, e.n);
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_reset_mid_op();
        exp_t e; logic [3:0] g; bit to; int n;
        clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        mq = 8'h00;
        sel[0] = 1'b1; data[7:0] = 8'h55; req = 4'b0001;
        push_op(pick(req), 1'b0);
        wait_gnt(g, to, n);
        e = sb.pop_front();
        checks++;
        if (to || g !== e.g) begin failures++; $display("FAIL mid_setup_gnt: got %b expected %b", g, e.g); end
        req = 4'b0000;
        @(negedge clk);
        checks++;
        if (Q !== 8'h55) begin failures++; $display("FAIL mid_setup_q: got %h expected 55", Q); end

        req = 4'b0010;
        @(posedge clk); #1 r = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0000) begin failures++; $display("FAIL mid_no_gnt: got %b expected 0000", gnt); end
        @(negedge clk);
        checks++;
        if (Q !== 8'h00 || ops !== 8'h00 || gnt !== 4'b0000 || busy !== 1'b0) begin
            failures++; $display("FAIL mid_reset_state: got Q=%h ops=%h gnt=%b busy=%b expected 00 00 0000 0",
                                 Q, ops, gnt, busy);
        end
        r = 1'b0; req = 4'b0000;
        model_reset();

        sel[0] = 1'b1; data[7:0] = 8'h5A; req = 4'b1001;
        push_op(pick(req), 1'b0);
        wait_gnt(g, to, n);
        e = sb.pop_front();
        checks++;
        if (to || g !== e.g) begin failures++; $display("FAIL mid_restart_gnt: got %b expected %b", g, e.g); end
        req = 4'b0000;
        @(negedge clk);
        checks++;
        if (Q !== e.q || ops !== e.n) begin
            failures++; $display("FAIL mid_restart_q: got Q=%h ops=%h expected Q=%h ops=%h", Q, ops, e.q, e.n);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_pointer_skip();
        test_clr();
        test_back_to_back();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/acc_arbiter.md
Name: acc_arbiter

Overview:
Round-robin arbiter and sequencer that shares one WIDTH-bit XOR/AND accumulator register between N_REQ requesters. Each requester posts an operation (XOR or AND) with an operand. The block grants one request at a time, applies it to the accumulator, and acknowledges with a one-cycle grant pulse. It sits between the client logic and the accumulator datapath. It is the only writer of the accumulator.

Parameters:
WIDTH, 8, accumulator and operand width (must be >= 4)
N_REQ, 4, number of requesters (2..8)

Ports:
clk  input  1  clock; all state changes on the rising edge
r  input  1  reset, synchronous, active-high
req  input  N_REQ  per-requester request; held high until that requester's gnt bit pulses
sel  input  N_REQ  per-requester op select: 1 = XOR, 0 = AND
data  input  N_REQ*WIDTH  per-requester operand; requester i uses data[i*WIDTH +: WIDTH]
clr  input  1  synchronous accumulator clear
gnt  output  N_REQ  one-hot grant/ack pulse, one cycle, registered-state decode
busy  output  1  high while an op is executing (state EXEC)
Q  output  WIDTH  accumulator value
L  output  4  Q[WIDTH-1:WIDTH-4]
ops  output  8  count of applied ops, wraps 255 -> 0

Behaviour:
- Reset (r=1 at a clock edge) has priority over everything else.
  - Q=0, ops=0, gnt=0, busy=0.
  - Round-robin pointer ptr=0, state=IDLE, latched operand and op = 0.
- FSM has two states, IDLE and EXEC.
- IDLE behaviour:
  - If req != 0, the winner w is the first set req bit searching ptr, ptr+1, ... with wrap modulo N_REQ.
  - At that edge, latch w, sel[w] and data[w], then go to EXEC.
  - If req == 0, stay in IDLE.
  - gnt=0 and busy=0 throughout IDLE.
- EXEC behaviour:
  - gnt = one-hot(w) and busy=1 for exactly this one cycle.
  - At the edge ending EXEC:
    - XOR op: Q <= Q ^ operand; AND op: Q <= Q & operand.
    - ops <= ops+1.
    - ptr <= (w+1) mod N_REQ.
    - State returns to IDLE.
- Latency and throughput:
  - Request seen in IDLE cycle t gives gnt in cycle t+1.
  - The new Q is visible in cycle t+2.
  - Peak throughput is one op per 2 cycles.
- Operands are sampled only at the IDLE->EXEC edge. Later changes to data, sel or req are ignored for the op in flight.
- Requester protocol:
  - Dropping req before a grant withdraws the request with no side effects.
  - A requester that keeps req high after its gnt pulse has posted a new request. Because ptr has advanced past it, other pending requesters win first.
- clr (priority: below r, above the EXEC update):
  - In IDLE: Q <= 0; the FSM is unaffected.
  - In EXEC: Q <= 0, the op is discarded and ops is not incremented. gnt still pulses, ptr still advances, and the op counts as consumed.
- Reset asserted during EXEC:
  - No gnt pulse; the op is lost.
  - All state returns to reset values on that edge.
- N_REQ not a power of two: ptr wrap uses an explicit compare to N_REQ-1, never truncation.
- No combinational path from req, sel or data to any output.

Decomposition:
- Package acc_pkg holds:
  - state_t enum {IDLE, EXEC}.
  - Constants OP_AND=1'b0 and OP_XOR=1'b1.
- Sub-module acc_unit:
  - WIDTH-bit register with synchronous active-high reset r, clr, en, op and operand inputs.
  - Output Q.
  - acc_arbiter instantiates one and drives en only in EXEC.
- Arbitration (rotating priority search) and the FSM live in acc_arbiter.

Test Plan:
- Reset: r=1 for 2 cycles with req=4'b1111 -> Q=8'h00, gnt=0, busy=0, ops=0; no grant during reset.
- Single XOR: in IDLE, req=4'b0001, sel[0]=1, data0=8'hA5 -> next cycle gnt=4'b0001, busy=1; the following cycle Q=8'hA5, L=4'hA, ops=1. Then req0 AND with 8'h0F -> Q=8'h05, ops=2.
- Round-robin fairness:
  - Setup: from reset, req=4'b1111 held, all XOR, data0..3=8'h01,8'h02,8'h04,8'h08.
  - Grants: gnt order 0,1,2,3,0 in cycles 1,3,5,7,9.
  - Result: Q=8'h0F after the 4th op and 8'h0E after the 5th.
- Pointer skip: ptr=2, req=4'b0011 -> requester 0 granted first, then 1; a requester 3 that drops req before IDLE is never granted.
- clr collision:
  - Setup: Q=8'h3C; op XOR 8'hFF enters EXEC with clr=1 in that cycle.
  - Result: gnt pulses, Q=8'h00, ops unchanged.
- Reset mid-op:
  - Setup: Q=8'h55; r=1 in an EXEC cycle.
  - Result: no gnt, Q=8'h00, ops=0, next grant search starts at requester 0.
